// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one 32-bit Ethernet TX stream between N frame senders.
// Grants a sender, pulses its start, then passes its stream to the MAC until eop.
module eth_tx_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      i_req,
    input  logic [N-1:0]      i_src_ready,
    output logic [N-1:0]      o_sync,
    input  logic [32*N-1:0]   i_src_data,
    input  logic [N-1:0]      i_src_sop,
    input  logic [N-1:0]      i_src_eop,
    input  logic [N-1:0]      i_src_vld,
    output logic [N-1:0]      o_src_rdy,
    output logic [31:0]       o_eth_data,
    output logic              o_eth_sop,
    output logic              o_eth_eop,
    output logic              o_eth_vld,
    input  logic              i_eth_rdy,
    output logic [N-1:0]      o_grant,
    output logic              o_busy,
    output logic              o_timeout
);

    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 16;

    localparam logic [CW-1:0]   WD_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]   GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic            WD_EN    = (TIMEOUT > 0);
    localparam logic            GAP_EN   = (GAP > 0);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_SOP,
        ST_XFER,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [N-1:0]    sync_q, sync_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
    logic            frame_end;

    logic [N-1:0]    eligible;
    logic            pick_vld;
    logic [IDXW-1:0] pick_idx;
    logic [IDXW-1:0] cand;
    logic [N-1:0]    pick_oh;

    logic [DW-1:0]   src_word [N];
    logic            g_vld, g_sop, g_eop;
    logic            pass;

    assign eligible = i_req & i_src_ready;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        pick_oh  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IDXW'((32'(last_q) + i) % N);
            if (!pick_vld && eligible[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
        pick_oh[pick_idx] = pick_vld;
    end

    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            src_word[k] = i_src_data[DW*k +: DW];
        end
    end

    // The granted index is always held in last_q while a grant is active.
    assign g_vld = i_src_vld[last_q];
    assign g_sop = i_src_sop[last_q];
    assign g_eop = i_src_eop[last_q];
    assign pass  = (state_q == ST_WAIT_SOP) || (state_q == ST_XFER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= LAST_RST;
            sync_q    <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            gap_cnt_q <= '0;
            wd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            sync_q    <= sync_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            gap_cnt_q <= gap_cnt_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        sync_d    = '0;
        timeout_d = 1'b0;
        gap_cnt_d = gap_cnt_q;
        wd_cnt_d  = wd_cnt_q;
        frame_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_oh;
                    last_d  = pick_idx;
                    sync_d  = pick_oh;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                wd_cnt_d = '0;
                state_d  = ST_WAIT_SOP;
            end
            ST_WAIT_SOP: begin
                if (g_vld && g_sop && i_eth_rdy) begin
                    if (g_eop) begin
                        frame_end = 1'b1;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
                    timeout_d = 1'b1;
                    frame_end = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
            end
            ST_XFER: begin
                if (g_vld && g_eop && i_eth_rdy) begin
                    frame_end = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A zero gap returns straight to IDLE so the next grant is not delayed.
        if (frame_end) begin
            grant_d   = '0;
            gap_cnt_d = '0;
            state_d   = GAP_EN ? ST_GAP : ST_IDLE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Combinational pass-through; non-sop beats before the frame starts are drained.
    always_comb begin
        o_eth_data = '0;
        o_eth_sop  = 1'b0;
        o_eth_eop  = 1'b0;
        o_eth_vld  = 1'b0;
        o_src_rdy  = '0;
        if (pass) begin
            o_eth_data        = src_word[last_q];
            o_eth_sop         = g_sop;
            o_eth_eop         = g_eop;
            o_src_rdy[last_q] = i_eth_rdy;
            if (state_q == ST_WAIT_SOP) begin
                o_eth_vld = g_vld & g_sop;
                if (g_vld && !g_sop) begin
                    o_src_rdy[last_q] = 1'b1;
                end
            end else begin
                o_eth_vld = g_vld;
            end
        end
    end

    assign o_sync    = sync_q;
    assign o_grant   = grant_q;
    assign o_busy    = busy_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed testbench for eth_tx_arbiter: grant order, pass-through, backpressure,
// watchdog abort, single-word frames and mid-frame reset.
module tb_eth_tx_arbiter;

    localparam int unsigned N       = 4;
    localparam int unsigned GAP     = 2;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      i_req;
    logic [N-1:0]      i_src_ready;
    logic [N-1:0]      o_sync;
    logic [32*N-1:0]   i_src_data;
    logic [N-1:0]      i_src_sop;
    logic [N-1:0]      i_src_eop;
    logic [N-1:0]      i_src_vld;
    logic [N-1:0]      o_src_rdy;
    logic [31:0]       o_eth_data;
    logic              o_eth_sop;
    logic              o_eth_eop;
    logic              o_eth_vld;
    logic              i_eth_rdy;
    logic [N-1:0]      o_grant;
    logic              o_busy;
    logic              o_timeout;

    int errors = 0;
    int checks = 0;

    eth_tx_arbiter #(.N(N), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_src_ready (i_src_ready),
        .o_sync      (o_sync),
        .i_src_data  (i_src_data),
        .i_src_sop   (i_src_sop),
        .i_src_eop   (i_src_eop),
        .i_src_vld   (i_src_vld),
        .o_src_rdy   (o_src_rdy),
        .o_eth_data  (o_eth_data),
        .o_eth_sop   (o_eth_sop),
        .o_eth_eop   (o_eth_eop),
        .o_eth_vld   (o_eth_vld),
        .i_eth_rdy   (i_eth_rdy),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_src();
        i_src_vld  = '0;
        i_src_sop  = '0;
        i_src_eop  = '0;
        i_src_data = '0;
    endtask

    task automatic set_beat(input int ch, input logic v, input logic s, input logic e,
                            input logic [31:0] d);
        clear_src();
        i_src_vld[ch]          = v;
        i_src_sop[ch]          = s;
        i_src_eop[ch]          = e;
        i_src_data[32*ch +: 32] = d;
    endtask

    // Advance on negedges until o_sync fires or the budget runs out.
    task automatic wait_sync(output int k);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (o_sync == '0 && k < 20);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        i_req       = '0;
        i_src_ready = '1;
        i_eth_rdy   = 1'b1;
        clear_src();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (o_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
        checks++; if (o_sync !== 4'b0000) begin errors++; $display("FAIL reset_sync: got %b want 0000", o_sync); end
        checks++; if (o_busy !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL reset_busy_to: got %b%b want 00", o_busy, o_timeout); end
        checks++; if (o_eth_vld !== 1'b0 || o_src_rdy !== 4'b0000) begin errors++; $display("FAIL reset_stream: vld %b rdy %b want 0 0000", o_eth_vld, o_src_rdy); end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        @(negedge clk);
        i_req = 4'b0010;
        @(negedge clk);
        #1;
        checks++; if (o_sync !== 4'b0010 || o_grant !== 4'b0010) begin errors++; $display("FAIL single_sync: sync %b grant %b want 0010 0010", o_sync, o_grant); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", o_busy); end
        i_req = '0;
        @(negedge clk);
        #1;
        checks++; if (o_sync !== 4'b0000) begin errors++; $display("FAIL single_sync_pulse: got %b want 0000", o_sync); end
        for (int b = 0; b < 5; b++) begin
            set_beat(1, 1'b1, b == 0, b == 4, 32'hA000_0000 + 32'(b));
            #1;
            checks++;
            if (o_eth_vld !== 1'b1 || o_eth_sop !== (b == 0) || o_eth_eop !== (b == 4) ||
                o_eth_data !== 32'hA000_0000 + 32'(b)) begin
                errors++;
                $display("FAIL single_beat%0d: vld %b sop %b eop %b data %h want 1 %b %b %h",
                         b, o_eth_vld, o_eth_sop, o_eth_eop, o_eth_data, b == 0, b == 4, 32'hA000_0000 + 32'(b));
            end
            checks++; if (o_src_rdy !== 4'b0010) begin errors++; $display("FAIL single_rdy%0d: got %b want 0010", b, o_src_rdy); end
            @(negedge clk);
        end
        clear_src();
        #1;
        checks++; if (o_grant !== 4'b0000 || o_busy !== 1'b1 || o_eth_vld !== 1'b0) begin errors++; $display("FAIL single_gap1: grant %b busy %b vld %b want 0000 1 0", o_grant, o_busy, o_eth_vld); end
        @(negedge clk);
        #1;
        checks++; if (o_grant !== 4'b0000 || o_busy !== 1'b1) begin errors++; $display("FAIL single_gap2: grant %b busy %b want 0000 1", o_grant, o_busy); end
        @(negedge clk);
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_gap_end: busy %b want 0", o_busy); end
    endtask

    task automatic test_round_robin();
        int exp_ch [5];
        int k;
        exp_ch = '{0, 1, 2, 3, 0};
        @(negedge clk);
        rst   = 1'b1;
        i_req = '0;
        clear_src();
        @(negedge clk);
        rst   = 1'b0;
        i_req = 4'b1111;
        wait_sync(k);
        for (int f = 0; f < 5; f++) begin
            checks++; if (o_sync !== 4'(1 << exp_ch[f])) begin errors++; $display("FAIL rr_order%0d: got %b want %b", f, o_sync, 4'(1 << exp_ch[f])); end
            if (f > 0) begin
                checks++; if (k !== int'(GAP) + 2) begin errors++; $display("FAIL rr_spacing%0d: got %0d want %0d", f, k, GAP + 2); end
            end
            if (f == 4) i_req = '0;
            @(negedge clk);
            set_beat(exp_ch[f], 1'b1, 1'b1, 1'b0, 32'hB000_0000 + 32'(f));
            @(negedge clk);
            set_beat(exp_ch[f], 1'b1, 1'b0, 1'b1, 32'hB100_0000 + 32'(f));
            #1;
            checks++; if (o_eth_vld !== 1'b1 || o_eth_eop !== 1'b1 || o_src_rdy !== 4'(1 << exp_ch[f])) begin errors++; $display("FAIL rr_eop%0d: vld %b eop %b rdy %b", f, o_eth_vld, o_eth_eop, o_src_rdy); end
            k = 0;
            do begin
                @(negedge clk);
                clear_src();
                #1;
                k++;
            end while (o_sync == '0 && k < 20);
        end
    endtask

    task automatic test_backpressure();
        int   w;
        int   c;
        logic r;
        @(negedge clk);
        i_req = 4'b0100;
        wait_sync(c);
        checks++; if (o_sync !== 4'b0100) begin errors++; $display("FAIL bp_sync: got %b want 0100", o_sync); end
        i_req = '0;
        @(negedge clk);
        w = 0;
        c = 0;
        r = 1'b1;
        while (w < 4 && c < 20) begin
            set_beat(2, 1'b1, w == 0, w == 3, 32'hC000_0000 + 32'(w));
            i_eth_rdy = r;
            #1;
            checks++; if (o_src_rdy !== (r ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL bp_rdy_c%0d: got %b want %b", c, o_src_rdy, r ? 4'b0100 : 4'b0000); end
            checks++; if (o_eth_vld !== 1'b1 || o_eth_data !== 32'hC000_0000 + 32'(w)) begin errors++; $display("FAIL bp_data_c%0d: vld %b data %h want 1 %h", c, o_eth_vld, o_eth_data, 32'hC000_0000 + 32'(w)); end
            if (r) w++;
            r = ~r;
            c++;
            @(negedge clk);
        end
        i_eth_rdy = 1'b1;
        clear_src();
        #1;
        checks++; if (w !== 4 || o_grant !== 4'b0000 || o_busy !== 1'b1) begin errors++; $display("FAIL bp_done: words %0d grant %b busy %b want 4 0000 1", w, o_grant, o_busy); end
        c = 0;
        while (o_busy && c < 10) begin
            @(negedge clk);
            #1;
            c++;
        end
    endtask

    task automatic test_timeout();
        int k;
        @(negedge clk);
        i_req = 4'b1001;
        wait_sync(k);
        checks++; if (o_sync !== 4'b1000) begin errors++; $display("FAIL to_sync: got %b want 1000", o_sync); end
        @(negedge clk);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!o_timeout && k < 40);
        checks++; if (o_timeout !== 1'b1 || k !== int'(TIMEOUT)) begin errors++; $display("FAIL to_pulse: timeout %b after %0d cycles want 1 after %0d", o_timeout, k, TIMEOUT); end
        checks++; if (o_grant !== 4'b0000) begin errors++; $display("FAIL to_grant: got %b want 0000", o_grant); end
        @(negedge clk);
        #1;
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b want 0", o_timeout); end
        wait_sync(k);
        checks++; if (o_sync !== 4'b0001) begin errors++; $display("FAIL to_next: got %b want 0001", o_sync); end
        i_req = '0;
        @(negedge clk);
        set_beat(0, 1'b1, 1'b1, 1'b1, 32'h0000_00D0);
        @(negedge clk);
        clear_src();
        #1;
        checks++; if (o_grant !== 4'b0000 || o_busy !== 1'b1) begin errors++; $display("FAIL to_ch0_done: grant %b busy %b want 0000 1", o_grant, o_busy); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_single_word();
        int k;
        @(negedge clk);
        i_req = 4'b1000;
        wait_sync(k);
        checks++; if (o_sync !== 4'b1000) begin errors++; $display("FAIL sw_sync: got %b want 1000", o_sync); end
        i_req = '0;
        @(negedge clk);
        set_beat(3, 1'b1, 1'b0, 1'b0, 32'hDEAD_0003);
        i_eth_rdy = 1'b0;
        #1;
        checks++; if (o_eth_vld !== 1'b0) begin errors++; $display("FAIL sw_drop_vld: got %b want 0", o_eth_vld); end
        checks++; if (o_src_rdy !== 4'b1000) begin errors++; $display("FAIL sw_drop_rdy: got %b want 1000", o_src_rdy); end
        @(negedge clk);
        set_beat(3, 1'b1, 1'b1, 1'b1, 32'hE000_0003);
        i_eth_rdy = 1'b1;
        #1;
        checks++; if (o_eth_vld !== 1'b1 || o_eth_sop !== 1'b1 || o_eth_eop !== 1'b1 || o_eth_data !== 32'hE000_0003) begin errors++; $display("FAIL sw_beat: vld %b sop %b eop %b data %h want 1 1 1 e0000003", o_eth_vld, o_eth_sop, o_eth_eop, o_eth_data); end
        @(negedge clk);
        clear_src();
        i_req = 4'b1001;
        #1;
        checks++; if (o_grant !== 4'b0000 || o_busy !== 1'b1) begin errors++; $display("FAIL sw_gap: grant %b busy %b want 0000 1", o_grant, o_busy); end
        wait_sync(k);
        checks++; if (o_sync !== 4'b0001) begin errors++; $display("FAIL sw_resume: got %b want 0001", o_sync); end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        set_beat(0, 1'b1, 1'b1, 1'b0, 32'h0000_00F0);
        @(negedge clk);
        set_beat(0, 1'b1, 1'b0, 1'b0, 32'h0000_00F1);
        #1;
        checks++; if (o_eth_vld !== 1'b1 || o_eth_data !== 32'h0000_00F1) begin errors++; $display("FAIL rst_xfer: vld %b data %h want 1 000000f1", o_eth_vld, o_eth_data); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (o_eth_vld !== 1'b0 || o_grant !== 4'b0000 || o_busy !== 1'b0) begin errors++; $display("FAIL rst_idle: vld %b grant %b busy %b want 0 0000 0", o_eth_vld, o_grant, o_busy); end
        checks++; if (o_src_rdy !== 4'b0000) begin errors++; $display("FAIL rst_rdy: got %b want 0000", o_src_rdy); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (o_sync !== 4'b0001) begin errors++; $display("FAIL rst_regrant: got %b want 0001", o_sync); end
        i_req = '0;
        clear_src();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_single_word();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Shares the single Ethernet TX stream between N frame senders: the ping responder, ARP responder and bulk-data IP sender. It grants one requester at a time in round-robin order and fires that sender's one-cycle start pulse. It then passes the sender's 32-bit sop/eop/vld/rdy stream through to the MAC until the frame's eop beat is accepted. A watchdog releases the channel if a started sender never produces sop, and a programmable idle gap separates frames.

## Interface
- N, 4: number of requester channels (2..8).
- GAP, 2: idle cycles inserted after each frame or abort (0 allowed).
- TIMEOUT, 1024: max cycles from start pulse to first sop beat; 0 disables the watchdog.
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain, synchronous, active-high.
- i_req  in  N  per-channel frame pending (level).
- i_src_ready  in  N  per-channel sender idle (sender's ready output).
- o_sync  out  N  one-hot, one-cycle start pulse to the granted sender.
- i_src_data  in  32*N  channel k occupies bits [32k+31:32k].
- i_src_sop, i_src_eop, i_src_vld  in  N  per-channel stream flags.
- o_src_rdy  out  N  per-channel backpressure.
- o_eth_data  out  32  muxed frame word.
- o_eth_sop, o_eth_eop, o_eth_vld  out  1  muxed stream flags.
- i_eth_rdy  in  1  MAC accepts the beat when o_eth_vld & i_eth_rdy.
- o_grant  out  N  one-hot current owner; 0 when idle or in the gap.
- o_busy  out  1  state is not IDLE.
- o_timeout  out  1  one-cycle pulse when the watchdog aborts a grant.

## Operation
- States: IDLE, START, WAIT_SOP, XFER, GAP.
- Eligibility: channel k is eligible when i_req[k] & i_src_ready[k].
- IDLE
  - If any channel is eligible, pick the first eligible channel searching from last+1 upward, modulo N.
  - Register the pick into o_grant and last, then go to START.
  - last resets to N-1, so channel 0 wins first.
- START (1 cycle): o_sync = o_grant, then go to WAIT_SOP.
- Pass-through while in WAIT_SOP or XFER (g = granted channel):
  - o_eth_data, sop and eop come from channel g.
  - o_src_rdy[g] = i_eth_rdy.
  - All other o_src_rdy bits are 0.
- WAIT_SOP
  - o_eth_vld = i_src_vld[g] & i_src_sop[g].
  - A beat with vld and no sop is dropped: o_src_rdy[g] = 1 and the beat is not forwarded.
  - A sop beat accepted with eop also set: go to GAP (single-word frame).
  - A sop beat accepted without eop: go to XFER.
  - Watchdog counter cleared on entry. If it reaches TIMEOUT with no sop accepted: pulse o_timeout and go to GAP.
- XFER
  - o_eth_vld = i_src_vld[g].
  - A beat accepted with eop: go to GAP.
  - Extra sop beats are forwarded unchanged. No checking in XFER.
- GAP
  - o_grant = 0, all o_src_rdy = 0, o_eth_vld = 0.
  - Lasts GAP cycles, then IDLE. With GAP = 0, go to IDLE on the next cycle.
- In any state other than WAIT_SOP/XFER: o_eth_vld = 0, o_src_rdy = 0, o_eth_sop/eop/data = 0.
- i_req dropping after the grant is ignored; the granted frame runs to completion.

## Timing
- Reset values, registered on the first clk edge with rst = 1:
  - state IDLE, o_grant 0, last N-1, gap and watchdog counters 0.
  - o_sync, o_timeout, o_busy and o_eth_vld are all 0.
- Grant latency: eligible request sampled in IDLE at cycle t → o_grant valid at t+1 (START, o_sync = 1) → WAIT_SOP at t+2.
- Data path is combinational: zero-cycle latency from source to MAC, and from i_eth_rdy to o_src_rdy.
- Eop acceptance at cycle t → GAP from t+1. Next o_sync is at the earliest t+GAP+2.
- Simultaneous eligible requests: round-robin only. A channel that just finished has lowest priority next.
- Reset mid-frame: output goes idle after the edge. No eop is generated; the truncated frame is the MAC's concern.
- Watchdog counts WAIT_SOP cycles including stalled ones. Counter width is 16 bits, so TIMEOUT ≤ 65535.

## Test plan
- Single request, ch1, 5-word frame, i_eth_rdy = 1:
  - o_sync[1] pulses 1 cycle after i_req.
  - 5 beats appear on o_eth_* with sop on beat 1 and eop on beat 5.
  - o_grant = 0 for exactly GAP cycles afterwards.
- All 4 channels request continuously: grant order is 0,1,2,3,0. Each frame completes before the next o_sync.
- Backpressure: i_eth_rdy toggles 1010 during a 4-word frame from ch2.
  - o_src_rdy[2] mirrors i_eth_rdy.
  - Data order is preserved.
  - Non-granted o_src_rdy bits stay 0.
- Sender silent after sync, TIMEOUT = 16: o_timeout pulses 16 cycles after entering WAIT_SOP, then GAP, then the next channel is granted.
- Single-word frame (sop & eop on the same beat) on ch3: goes straight to GAP, and round-robin resumes at ch0.
- rst asserted mid-XFER of ch0: o_eth_vld = 0 and o_grant = 0 next cycle. After release, ch0 is granted first again (last = N-1).
